// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and sizing constants.
package imem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRecv   = 2'd1,
        StWrite  = 2'd2,
        StFinish = 2'd3
    } state_e;

endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream into 32-bit words, most-significant byte first.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_xfer,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_last
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_xfer) begin
            r_word <= {r_word[23:0], i_byte};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    // Flags the transfer that completes the word, so the FSM can move to WRITE on that edge.
    assign o_last = i_xfer && (r_cnt == 2'(WORD_BYTES - 1));
    assign o_word = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: streams bytes into instruction memory while holding the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(WORD_BYTES);
    // Largest word count that fits the address space; longer requests are clipped.
    localparam logic [ADDR_W-1:0] MaxWords = ADDR_W'((2 ** ADDR_W) / WORD_BYTES);

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_d;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_d;
    logic              w_clr;
    logic              w_xfer;
    logic              w_last;
    logic [31:0]       w_word;

    assign w_xfer = byte_valid && byte_ready;

    byte_assembler u_byte_assembler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_xfer (w_xfer),
        .i_byte (byte_data),
        .o_word (w_word),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_addr  <= BaseAddr;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_addr  <= w_addr_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_addr_d   = r_addr;
        w_clr      = 1'b0;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_clr = 1'b1;
                    if (num_words == '0) begin
                        w_state_d = StFinish;
                    end else begin
                        w_cnt_d   = (num_words > MaxWords) ? MaxWords : num_words;
                        w_addr_d  = BaseAddr;
                        w_state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                byte_ready = 1'b1;
                if (w_last) begin
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                wr_en     = 1'b1;
                w_addr_d  = r_addr + AddrStep;
                w_cnt_d   = r_cnt - ADDR_W'(1);
                w_state_d = (r_cnt == ADDR_W'(1)) ? StFinish : StRecv;
            end
            StFinish: begin
                done      = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign busy     = (r_state != StIdle);
    assign cpu_hold = busy;
    assign wr_addr  = r_addr;
    assign wr_data  = w_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with hand-computed expected writes.
module tb_imem_loader;

    localparam int unsigned AW = 9;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] num_words;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold;
    logic          busy;
    logic          done;

    imem_loader #(
        .ADDR_W    (AW),
        .BASE_ADDR (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_words  (num_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cyc = -1;

    logic [AW-1:0] addr_q[$];
    logic [31:0]   data_q[$];
    int            wcyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done log, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            addr_q.push_back(wr_addr);
            data_q.push_back(wr_data);
            wcyc_q.push_back(cyc);
        end
        if (done) done_cyc = cyc;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        addr_q.delete();
        data_q.delete();
        wcyc_q.delete();
        done_cyc = -1;
    endtask

    task automatic start_load(input logic [AW-1:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            byte_data  = 8'h5A;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_wr_en"}, 32'(wr_en), 32'd0);
        check_eq({pfx, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_eq({pfx, "_wr_data"}, wr_data, 32'd0);
        check_eq({pfx, "_ready"}, 32'(byte_ready), 32'd0);
        check_eq({pfx, "_hold"}, 32'(cpu_hold), 32'd0);
        check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
        check_eq({pfx, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int bad;
        int n;
        logic [31:0] exp_w;
        logic [7:0]  b;

        rst_n      = 1'b0;
        start      = 1'b0;
        num_words  = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two words, byte_valid held high.
        clear_log();
        start_load(AW'(2));
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_hold", 32'(cpu_hold), 32'd1);
        send_word(32'h2008_0005, 1'b0);
        check_eq("t1_lat_wr_en", 32'(wr_en), 32'd1);
        check_eq("t1_w0_data", wr_data, 32'h2008_0005);
        check_eq("t1_w0_addr", 32'(wr_addr), 32'd0);
        send_word(32'h0000_000A, 1'b0);
        check_eq("t1_w1_data", wr_data, 32'h0000_000A);
        check_eq("t1_w1_addr", 32'(wr_addr), 32'd4);
        byte_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_done", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("t1_done_after_wr", 32'(done_cyc - wcyc_q[wcyc_q.size()-1]), 32'd1);
        check_eq("t1_hold_after", 32'(cpu_hold), 32'd0);
        check_eq("t1_done_low", 32'(done), 32'd0);
        check_eq("t1_nwrites", 32'(addr_q.size()), 32'd2);

        // One word with byte_valid toggling every cycle.
        clear_log();
        start_load(AW'(1));
        send_word(32'hDEAD_BEEF, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("t2_nwrites", 32'(addr_q.size()), 32'd1);
        if (addr_q.size() == 1) begin
            check_eq("t2_data", data_q[0], 32'hDEAD_BEEF);
            check_eq("t2_addr", 32'(addr_q[0]), 32'd0);
        end
        check_eq("t2_idle", 32'(busy), 32'd0);

        // Zero-word request.
        clear_log();
        start_load(AW'(0));
        check_eq("t3_busy", 32'(busy), 32'd1);
        check_eq("t3_done", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("t3_busy_off", 32'(busy), 32'd0);
        check_eq("t3_done_off", 32'(done), 32'd0);
        check_eq("t3_nwrites", 32'(addr_q.size()), 32'd0);

        // Oversized request is clipped to 128 words, last at 508.
        clear_log();
        start_load(AW'(200));
        for (int i = 0; i < 512; i++) begin
            b = 8'(i);
            send_byte(b, 1'b0);
        end
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_done_seen", 32'(done), 32'd1);
        repeat (10) @(negedge clk);
        byte_valid = 1'b0;
        check_eq("t4_nwrites", 32'(addr_q.size()), 32'd128);
        bad = 0;
        for (int k = 0; k < addr_q.size(); k++) begin
            exp_w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            if (data_q[k] !== exp_w || 32'(addr_q[k]) !== 32'(4*k)) bad++;
        end
        check_eq("t4_bad_words", 32'(bad), 32'd0);
        if (addr_q.size() > 0) begin
            check_eq("t4_last_addr", 32'(addr_q[addr_q.size()-1]), 32'd508);
            check_eq("t4_last_data", data_q[data_q.size()-1], 32'hFCFD_FEFF);
        end
        check_eq("t4_busy_off", 32'(busy), 32'd0);

        // Reset two bytes into the second word.
        clear_log();
        start_load(AW'(3));
        send_word(32'h1111_2222, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        byte_valid = 1'b0;
        check_eq("t5_nwrites_abort", 32'(addr_q.size()), 32'd1);
        start_load(AW'(1));
        send_word(32'h1122_3344, 1'b0);
        repeat (2) @(negedge clk);
        byte_valid = 1'b0;
        check_eq("t5_nwrites", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() == 2) begin
            check_eq("t5_reload_addr", 32'(addr_q[1]), 32'd0);
            check_eq("t5_reload_data", data_q[1], 32'h1122_3344);
        end

        // Start re-pulsed while receiving is ignored.
        clear_log();
        start_load(AW'(2));
        send_byte(8'hA1, 1'b0);
        start     = 1'b1;
        num_words = AW'(5);
        send_byte(8'hA2, 1'b0);
        start     = 1'b0;
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        send_word(32'hB1B2_B3B4, 1'b0);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_nwrites", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() == 2) begin
            check_eq("t6_addr0", 32'(addr_q[0]), 32'd0);
            check_eq("t6_addr1", 32'(addr_q[1]), 32'd4);
            check_eq("t6_data0", data_q[0], 32'hA1A2_A3A4);
            check_eq("t6_data1", data_q[1], 32'hB1B2_B3B4);
        end
        check_eq("t6_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
